// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
`default_nettype none

package reg_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_write_arbiter_if.sv
// Requester-side and register-file-side signals of the write-port arbiter.
`default_nettype none

interface reg_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_stall;
  logic              aux_valid;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              init_done;

  modport master (
    output wb_valid, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
    input  wb_stall, aux_ready, RegWrite, WriteReg, WriteData, init_done
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
    output wb_stall, aux_ready, RegWrite, WriteReg, WriteData, init_done
  );

endinterface

`default_nettype wire

// File: rtl/reg_write_arbiter_fifo.sv
// reg_wr_fifo: small power-of-two FIFO buffering aux writes; control state reset, storage not.
`default_nettype none

module reg_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  wire logic         CLK,
  input  wire logic         RST_n,
  input  wire logic         i_push,
  input  wire logic         i_pop,
  input  wire logic [W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [W-1:0]      o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: zero-sweeps the register file after reset, then shares its single
// write port between the writeback stage (priority) and a buffered aux requester.
`default_nettype none

module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int NUM_REGS     = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic          CLK,
  input  wire logic          RST_n,
  reg_write_arbiter_if.slave bus
);

  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] c_last_reg = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] c_reg_zero = ADDR_W'(REG_ZERO);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_sweep;
  logic [STV_W-1:0]  r_starve;
  logic              r_stall;

  logic              w_init_wr;
  logic              w_sel;
  logic              w_wb_win;
  logic              w_pop;
  logic              w_push;
  logic              w_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_full;
  logic              w_empty;
  logic [ENT_W-1:0]  w_head;

  reg_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({bus.aux_addr, bus.aux_data}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_wr   = 1'b0;
    w_sel       = 1'b0;
    w_wb_win    = 1'b0;
    w_pop       = 1'b0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    case (r_state)
      ST_INIT: begin
        w_init_wr = 1'b1;
        if (r_sweep == c_last_reg) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // While stalled the FIFO head wins even if wb_valid is (illegally) high.
        if (bus.wb_valid && !r_stall) begin
          w_sel      = 1'b1;
          w_wb_win   = 1'b1;
          w_sel_addr = bus.wb_addr;
          w_sel_data = bus.wb_data;
        end else if (!w_empty) begin
          w_sel      = 1'b1;
          w_pop      = 1'b1;
          w_sel_addr = w_head[DATA_W +: ADDR_W];
          w_sel_data = w_head[DATA_W-1:0];
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_we   = w_init_wr || (w_sel && (w_sel_addr != c_reg_zero));
  assign w_push = bus.aux_valid && bus.aux_ready;

  assign bus.RegWrite  = w_we;
  assign bus.WriteReg  = w_init_wr ? r_sweep : (w_we ? w_sel_addr : '0);
  assign bus.WriteData = (w_we && !w_init_wr) ? w_sel_data : '0;
  assign bus.aux_ready = (r_state == ST_RUN) && !w_full;
  assign bus.init_done = (r_state == ST_RUN);
  assign bus.wb_stall  = r_stall;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sweep <= '0;
    end else if (r_state == ST_INIT && r_sweep != c_last_reg) begin
      r_sweep <= r_sweep + ADDR_W'(1);
    end
  end

  // Stall is raised on the wb win that brings the count to the limit, dropped on the next pop.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else if (w_pop) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else if (w_wb_win && !w_empty) begin
      r_starve <= r_starve + STV_W'(1);
      if (r_starve + STV_W'(1) == STV_W'(STARVE_LIMIT)) r_stall <= 1'b1;
    end
  end

  a_no_wb_in_init: assert property (
    @(posedge CLK) disable iff (!RST_n) !(r_state == ST_INIT && bus.wb_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
`default_nettype none

module tb_reg_write_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int NUM_REGS     = 32;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic CLK   = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  reg_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_write_arbiter #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .NUM_REGS     (NUM_REGS),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  bit   m_run;
  int   m_sweep;
  int   m_wb_wins;
  bit   m_stall;
  ent_t m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_run     = 1'b0;
    m_sweep   = 0;
    m_wb_wins = 0;
    m_stall   = 1'b0;
    m_q.delete();
  endtask

  task automatic drive(input logic wv, input int wa, input logic [31:0] wd,
                       input logic av, input int aa, input logic [31:0] ad);
    bus.wb_valid  = wv;
    bus.wb_addr   = ADDR_W'(wa);
    bus.wb_data   = wd;
    bus.aux_valid = av;
    bus.aux_addr  = ADDR_W'(aa);
    bus.aux_data  = ad;
  endtask

  task automatic check_now(input string tag);
    logic              exp_we;
    logic [ADDR_W-1:0] exp_reg;
    logic [DATA_W-1:0] exp_data;
    bit                data_defined;
    exp_we       = 1'b0;
    exp_reg      = '0;
    exp_data     = '0;
    data_defined = 1'b1;
    if (!m_run) begin
      exp_we  = 1'b1;
      exp_reg = ADDR_W'(m_sweep);
    end else if (bus.wb_valid && !m_stall) begin
      exp_we       = (bus.wb_addr != 0);
      exp_reg      = exp_we ? bus.wb_addr : '0;
      exp_data     = bus.wb_data;
      data_defined = exp_we;
    end else if (m_q.size() > 0) begin
      exp_we       = (m_q[0].a != 0);
      exp_reg      = exp_we ? m_q[0].a : '0;
      exp_data     = m_q[0].d;
      data_defined = exp_we;
    end
    chk({tag, "/RegWrite"},  bus.RegWrite,  exp_we);
    chk({tag, "/WriteReg"},  bus.WriteReg,  exp_reg);
    if (data_defined) chk({tag, "/WriteData"}, bus.WriteData, exp_data);
    chk({tag, "/aux_ready"}, bus.aux_ready, m_run && (m_q.size() < FIFO_DEPTH));
    chk({tag, "/init_done"}, bus.init_done, m_run);
    chk({tag, "/wb_stall"},  bus.wb_stall,  m_stall);
  endtask

  // Check this cycle, cross the rising edge, apply the cycle's effect to the model.
  task automatic step(input string tag);
    bit   wb_win;
    bit   do_push;
    bit   do_pop;
    ent_t e;
    #1;
    check_now(tag);
    @(posedge CLK);
    if (!m_run) begin
      m_sweep++;
      if (m_sweep == NUM_REGS) m_run = 1'b1;
    end else begin
      wb_win  = bus.wb_valid && !m_stall;
      do_push = bus.aux_valid && (m_q.size() < FIFO_DEPTH);
      do_pop  = !wb_win && (m_q.size() > 0);
      if (wb_win && m_q.size() > 0) begin
        m_wb_wins++;
        if (m_wb_wins == STARVE_LIMIT) m_stall = 1'b1;
      end
      if (do_pop) begin
        e         = m_q.pop_front();
        m_wb_wins = 0;
        m_stall   = 1'b0;
      end
      if (do_push) begin
        e.a = bus.aux_addr;
        e.d = bus.aux_data;
        m_q.push_back(e);
      end
    end
    @(negedge CLK);
  endtask

  task automatic mid_reset(input string tag);
    #2;
    RST_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    reset_model();
    #1;
    check_now({tag, "_immediate"});
    @(negedge CLK);
    check_now({tag, "_held"});
    RST_n = 1'b1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < NUM_REGS; i++) step(tag);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    reset_model();
    RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    check_now("reset");
    RST_n = 1'b1;

    sweep("init");
    step("run_entry");

    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    step("wb_write");

    drive(0, 0, 0, 1, 3, 32'h11);
    step("aux_push1");
    drive(0, 0, 0, 1, 4, 32'h22);
    step("aux_push2");
    drive(0, 0, 0, 0, 0, 0);
    step("aux_drain1");
    step("aux_drain2");

    drive(1, 7, 32'h70, 1, 9, 32'h99);
    step("starve_push");
    for (int i = 0; i < 6; i++) begin
      drive(1, 10 + i, $urandom, 0, 0, 0);
      step("starve");
    end
    drive(0, 0, 0, 0, 0, 0);
    step("starve_idle");

    drive(1, 0, 32'h55, 0, 0, 0);
    step("wb_zero");
    drive(0, 0, 0, 1, 0, 32'h66);
    step("aux_zero_push");
    drive(0, 0, 0, 0, 0, 0);
    step("aux_zero_pop");
    step("aux_zero_empty");

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 31), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 31), $urandom);
      step("random");
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) step("random_drain");

    mid_reset("rst_a");
    for (int i = 0; i < 17; i++) step("init_partial");
    mid_reset("rst_mid_init");
    sweep("init_restart");

    drive(1, 1, 32'hA1, 1, 10, 32'hB0);
    step("fill1");
    drive(1, 2, 32'hA2, 1, 11, 32'hB1);
    step("fill2");
    drive(1, 3, 32'hA3, 1, 12, 32'hB2);
    step("full");
    mid_reset("rst_mid_run");
    sweep("init_after_run");
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 31), $urandom);
      step("random_post");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
